// File: rtl/mult_add_inv.sv
// rtl/mult_add_inv.sv - sequential inverse of multiply-add: a = (s - c) / b, signed Q1.(W-1)
// Radix-2 restoring divider with saturation and divide-by-zero flag, fixed 2W+1 cycle latency.
module mult_add_inv #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         val_in,
  input  logic [W-1:0] s,
  input  logic [W-1:0] c,
  input  logic [W-1:0] b,
  output logic [W-1:0] a,
  output logic         rdy_out,
  output logic         busy,
  output logic         div_err
);

  localparam int CW = $clog2(2 * W);
  localparam logic [CW-1:0] LAST_STEP = CW'(2 * W - 1);
  localparam logic [2*W-1:0] Q_POS_MAX = {{(W + 1){1'b0}}, {(W - 1){1'b1}}};
  localparam logic [2*W-1:0] Q_NEG_MAX = {{W{1'b0}}, 1'b1, {(W - 1){1'b0}}};
  localparam logic [W-1:0] A_POS_SAT = {1'b0, {(W - 1){1'b1}}};
  localparam logic [W-1:0] A_NEG_SAT = {1'b1, {(W - 1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   rem;
  logic [2*W-1:0] dvd;
  logic [W-1:0]   dvs;
  logic           neg, zero_b, d_neg;

  logic           load;
  logic [W:0]     d, d_abs;
  logic [W:0]     rem_sh;
  logic           q_bit;
  logic [W-1:0]   a_nxt;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (val_in) state_nxt = DIV;
      DIV:     if (cnt == LAST_STEP) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The rdy_out cycle is already IDLE, so a new operand can load there for back-to-back throughput.
  assign load = (state == IDLE) && val_in;

  always_comb begin
    d      = {s[W-1], s} - {c[W-1], c};
    d_abs  = d[W] ? -d : d;
    rem_sh = {rem, dvd[2*W-1]};
    q_bit  = rem_sh >= {1'b0, dvs};
  end

  always_comb begin
    a_nxt = '0;
    if (zero_b)         a_nxt = d_neg ? A_NEG_SAT : A_POS_SAT;
    else if (!neg)      a_nxt = (dvd > Q_POS_MAX) ? A_POS_SAT : dvd[W-1:0];
    else                a_nxt = (dvd >= Q_NEG_MAX) ? A_NEG_SAT : -dvd[W-1:0];
  end

  // Dividend bits shift out the top while quotient bits shift in at the bottom.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      rem     <= '0;
      dvd     <= '0;
      dvs     <= '0;
      neg     <= 1'b0;
      zero_b  <= 1'b0;
      d_neg   <= 1'b0;
      a       <= '0;
      rdy_out <= 1'b0;
      busy    <= 1'b0;
      div_err <= 1'b0;
    end else begin
      rdy_out <= (state == DONE);
      busy    <= load || (state == DIV) || (state == DONE);
      if (load) begin
        neg    <= d[W] ^ b[W-1];
        d_neg  <= d[W];
        zero_b <= (b == '0);
        dvd    <= {d_abs, {(W - 1){1'b0}}};
        dvs    <= b[W-1] ? -b : b;
        rem    <= '0;
        cnt    <= '0;
      end else if (state == DIV) begin
        // Remainder stays below the divisor, so W-bit wrap-around arithmetic is exact.
        rem <= rem_sh[W-1:0] - (q_bit ? dvs : '0);
        dvd <= {dvd[2*W-2:0], q_bit};
        cnt <= cnt + 1'b1;
      end else if (state == DONE) begin
        a       <= a_nxt;
        div_err <= zero_b;
      end
    end
  end

endmodule

// File: tb/tb_mult_add_inv.sv
// tb/tb_mult_add_inv.sv - directed self-checking bench for mult_add_inv
module tb_mult_add_inv;

  logic       clk = 1'b0;
  logic       reset, val_in;
  logic [7:0] s, c, b, a;
  logic       rdy_out, busy, div_err;
  int         n_vec = 0;
  int         n_err = 0;

  mult_add_inv #(.W(8)) dut (
    .clk(clk), .reset(reset), .val_in(val_in), .s(s), .c(c), .b(b),
    .a(a), .rdy_out(rdy_out), .busy(busy), .div_err(div_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [7:0] si, ci, bi, ea, input logic ee, input string tag);
    int lat;
    @(negedge clk);
    s = si; c = ci; b = bi; val_in = 1'b1;
    @(negedge clk);
    val_in = 1'b0;
    s = ~si; c = 8'h55; b = bi ^ 8'h3C;
    chk({tag, "_busy_start"}, 32'(busy), 32'd1);
    lat = 0;
    while (!rdy_out && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd17);
    chk({tag, "_a"}, 32'(a), 32'(ea));
    chk({tag, "_div_err"}, 32'(div_err), 32'(ee));
    chk({tag, "_busy_rdy"}, 32'(busy), 32'd1);
    @(negedge clk);
    chk({tag, "_rdy_width"}, 32'(rdy_out), 32'd0);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    chk({tag, "_a_hold"}, 32'(a), 32'(ea));
  endtask

  initial begin
    int first, second, npulse, nrdy;
    logic prev;
    reset = 1'b1; val_in = 1'b0; s = '0; c = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_a", 32'(a), 32'd0);
    chk("rst_rdy", 32'(rdy_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(div_err), 32'd0);
    reset = 1'b0;

    run_op(8'h20, 8'h00, 8'h40, 8'h40, 1'b0, "basic");
    run_op(8'hE0, 8'h00, 8'h40, 8'hC0, 1'b0, "neg_d");
    run_op(8'h10, 8'h30, 8'hC0, 8'h40, 1'b0, "neg_both");
    run_op(8'h01, 8'h00, 8'h03, 8'h2A, 1'b0, "trunc_pos");
    run_op(8'hFF, 8'h00, 8'h03, 8'hD6, 1'b0, "trunc_neg");
    run_op(8'h40, 8'h00, 8'h40, 8'h7F, 1'b0, "sat_pos");
    run_op(8'h80, 8'h7F, 8'h7F, 8'h80, 1'b0, "sat_neg");
    run_op(8'h40, 8'h00, 8'h80, 8'hC0, 1'b0, "b_min");
    run_op(8'h00, 8'h00, 8'h80, 8'h00, 1'b0, "neg_zero");
    run_op(8'h10, 8'h00, 8'h00, 8'h7F, 1'b1, "dz_pos");
    run_op(8'h80, 8'h00, 8'h00, 8'h80, 1'b1, "dz_neg");
    run_op(8'h20, 8'h00, 8'h40, 8'h40, 1'b0, "err_clear");

    // val_in held high: loads every 18 cycles, extra strobes dropped
    @(negedge clk);
    s = 8'h20; c = 8'h00; b = 8'h40; val_in = 1'b1;
    first = -1; second = -1; npulse = 0; prev = 1'b0;
    for (int k = 0; k <= 53; k++) begin
      @(negedge clk);
      if (rdy_out) begin
        npulse++;
        if (first < 0) first = k;
        else if (second < 0) second = k;
        chk("held_a", 32'(a), 32'h40);
        chk("held_no_b2b", 32'(prev), 32'd0);
      end
      prev = rdy_out;
    end
    val_in = 1'b0;
    chk("held_first", 32'(first), 32'd17);
    chk("held_second", 32'(second), 32'd35);
    chk("held_count", 32'(npulse), 32'd3);
    repeat (20) @(negedge clk);

    // reset mid-division after a divide-by-zero leaves non-zero outputs
    run_op(8'h80, 8'h00, 8'h00, 8'h80, 1'b1, "pre_rst");
    @(negedge clk);
    s = 8'h20; c = 8'h00; b = 8'h40; val_in = 1'b1;
    @(negedge clk);
    val_in = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_a", 32'(a), 32'd0);
    chk("abort_rdy", 32'(rdy_out), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_err", 32'(div_err), 32'd0);
    nrdy = 0;
    repeat (25) begin
      @(negedge clk);
      if (rdy_out) nrdy++;
    end
    chk("abort_no_rdy", 32'(nrdy), 32'd0);
    run_op(8'hFF, 8'h00, 8'h03, 8'hD6, 1'b0, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
